// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default geometry, lane count
// and the byte-lane alignment helper used when a store is accepted.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_AWIDTH = 14;
    localparam int SB_LANES  = 4;

    // Moves the unshifted register value onto the byte lanes selected by
    // the low address bits; bytes shifted past bit 31 are dropped.
    function automatic logic [31:0] sb_align(input logic [31:0] data,
                                             input logic [1:0]  offset);
        return data << {offset, 3'b000};
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundles the store-side, memory-side and load-lookup signals of the store
// buffer. The slave modport is the buffer's view; master is its environment.
interface store_buffer_if #(parameter int AWIDTH = store_buffer_pkg::SB_AWIDTH);

    logic                                st_valid;
    logic                                st_ready;
    logic [31:0]                         st_addr;
    logic [31:0]                         st_data;
    logic [store_buffer_pkg::SB_LANES-1:0] st_wea;

    logic                                mem_valid;
    logic                                mem_ready;
    logic [AWIDTH-1:0]                   mem_addr;
    logic [31:0]                         mem_din;
    logic [store_buffer_pkg::SB_LANES-1:0] mem_we;

    logic                                ld_valid;
    logic [31:0]                         ld_addr;
    logic                                ld_hazard;

    logic                                empty;
    logic                                full;

    modport slave (
        input  st_valid, st_addr, st_data, st_wea, mem_ready, ld_valid, ld_addr,
        output st_ready, mem_valid, mem_addr, mem_din, mem_we, ld_hazard, empty, full
    );

    modport master (
        output st_valid, st_addr, st_data, st_wea, mem_ready, ld_valid, ld_addr,
        input  st_ready, mem_valid, mem_addr, mem_din, mem_we, ld_hazard, empty, full
    );

endinterface

// File: rtl/store_buffer_fifo.sv
// Circular entry storage with head/tail pointers and an occupancy count.
// Exposes the head entry, each slot's tag bits and which slots are live so
// the enclosing buffer can run its load-hazard search.
module sb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 50,
    parameter int TAGW  = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [WIDTH-1:0]            wdata_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic [DEPTH-1:0][TAGW-1:0]  tags_o,
    output logic [DEPTH-1:0]            occupied_o,
    output logic                        empty_o,
    output logic                        full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pushOk;
    logic             popOk;
    logic [PW-1:0]    rel;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pushOk  = push_i & ~full_o;
    assign popOk   = pop_i & ~empty_o;
    assign rdata_o = mem_q[head_q];

    // Next pointer and count values; power-of-two depth makes wrap implicit.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pushOk) tail_d = tail_q + PW'(1);
        if (popOk)  head_d = head_q + PW'(1);
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count are the only state that decides what is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset since occupancy gates every use of it.
    always_ff @(posedge clk) begin
        if (pushOk) mem_q[tail_q] <= wdata_i;
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        rel        = '0;
        occupied_o = '0;
        tags_o     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel           = PW'(i) - head_q;
            occupied_o[i] = ({1'b0, rel} < count_q);
            tags_o[i]     = mem_q[i][WIDTH-1 -: TAGW];
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the pipeline and data memory: aligns incoming store
// data onto byte lanes, queues stores in order, presents the oldest one to
// memory and flags loads that overlap a store still waiting to be written.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int AWIDTH = SB_AWIDTH
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave sb
);

    localparam int TAGW = AWIDTH + SB_LANES;
    localparam int EW   = TAGW + 32;

    logic [EW-1:0]              wdata;
    logic [EW-1:0]              rdata;
    logic [DEPTH-1:0][TAGW-1:0] tags;
    logic [DEPTH-1:0]           occupied;
    logic                       push;
    logic                       pop;
    logic                       fifoEmpty;
    logic                       fifoFull;
    logic [AWIDTH-1:0]          ldWord;
    logic                       hazard;
    logic                       unusedAddrBits;

    // Stores with no enabled lane complete the handshake but are dropped.
    assign push  = sb.st_valid & ~fifoFull & (|sb.st_wea);
    assign pop   = sb.mem_ready & ~fifoEmpty;
    assign wdata = {sb.st_addr[AWIDTH+1:2], sb.st_wea, sb_align(sb.st_data, sb.st_addr[1:0])};

    sb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .TAGW  (TAGW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .tags_o     (tags),
        .occupied_o (occupied),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull)
    );

    assign sb.st_ready = ~fifoFull;
    assign sb.empty    = fifoEmpty;
    assign sb.full     = fifoFull;
    assign sb.mem_valid = ~fifoEmpty;
    assign sb.mem_addr  = rdata[EW-1 -: AWIDTH];
    assign sb.mem_din   = rdata[31:0];
    assign sb.mem_we    = fifoEmpty ? '0 : rdata[32 +: SB_LANES];

    assign ldWord = sb.ld_addr[AWIDTH+1:2];

    // Search every live slot, including the one leaving this cycle, for a
    // word match; a store arriving this cycle is not yet in storage.
    always_comb begin
        hazard = 1'b0;
        if (sb.ld_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occupied[i] && (tags[i][TAGW-1 -: AWIDTH] == ldWord) &&
                    (|tags[i][SB_LANES-1:0])) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign sb.ld_hazard = hazard;

    assign unusedAddrBits = ^{sb.st_addr[31:AWIDTH+2], sb.ld_addr[31:AWIDTH+2], sb.ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random
// traffic, checked by a monitor against a queue-based model of the buffer.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int AWIDTH = 14;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        we;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checkCount = 0;
    int     failCount = 0;
    entry_t modelQ[$];

    store_buffer_if #(.AWIDTH(AWIDTH)) sbIf();

    store_buffer #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbIf.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after the rising edge and settle before any check.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] w, input logic mr,
                                 input logic lv, input logic [31:0] la);
        @(posedge clk);
        #1;
        sbIf.st_valid  = v;
        sbIf.st_addr   = a;
        sbIf.st_data   = d;
        sbIf.st_wea    = w;
        sbIf.mem_ready = mr;
        sbIf.ld_valid  = lv;
        sbIf.ld_addr   = la;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    endtask

    // Monitor: checks DUT outputs against the model on every falling edge,
    // then advances the model by the handshakes the next rising edge takes.
    initial begin : monitor
        entry_t       e;
        logic         expHaz;
        logic         enq;
        logic         deq;
        logic [31:0]  ldA;
        forever begin
            @(negedge clk);
            if (rst) begin
                modelQ.delete();
                continue;
            end
            ldA = sbIf.ld_addr;
            expHaz = 1'b0;
            if (sbIf.ld_valid) begin
                foreach (modelQ[i]) begin
                    if (modelQ[i].addr == ldA[AWIDTH+1:2] && modelQ[i].we != 4'b0) expHaz = 1'b1;
                end
            end
            checkOutput("ld_hazard", 32'(sbIf.ld_hazard), 32'(expHaz));
            checkOutput("empty", 32'(sbIf.empty), 32'(modelQ.size() == 0));
            checkOutput("full", 32'(sbIf.full), 32'(modelQ.size() == DEPTH));
            checkOutput("st_ready", 32'(sbIf.st_ready), 32'(modelQ.size() != DEPTH));
            checkOutput("mem_valid", 32'(sbIf.mem_valid), 32'(modelQ.size() != 0));
            if (modelQ.size() != 0) begin
                checkOutput("mem_addr", 32'(sbIf.mem_addr), 32'(modelQ[0].addr));
                checkOutput("mem_din", sbIf.mem_din, modelQ[0].data);
                checkOutput("mem_we", 32'(sbIf.mem_we), 32'(modelQ[0].we));
            end else begin
                checkOutput("mem_we_idle", 32'(sbIf.mem_we), 32'h0);
            end
            deq = (modelQ.size() != 0) && sbIf.mem_ready;
            enq = sbIf.st_valid && (modelQ.size() < DEPTH) && (sbIf.st_wea != 4'b0);
            e.addr = sbIf.st_addr[AWIDTH+1:2];
            e.data = sbIf.st_data << (8 * sbIf.st_addr[1:0]);
            e.we   = sbIf.st_wea;
            if (deq) void'(modelQ.pop_front());
            if (enq) modelQ.push_back(e);
        end
    end

    initial begin : stimulus
        sbIf.st_valid  = 0;
        sbIf.st_addr   = 0;
        sbIf.st_data   = 0;
        sbIf.st_wea    = 0;
        sbIf.mem_ready = 0;
        sbIf.ld_valid  = 1;
        sbIf.ld_addr   = 0;

        // Reset values
        #12;
        checkOutput("rst_empty", 32'(sbIf.empty), 32'h1);
        checkOutput("rst_st_ready", 32'(sbIf.st_ready), 32'h1);
        checkOutput("rst_full", 32'(sbIf.full), 32'h0);
        checkOutput("rst_mem_valid", 32'(sbIf.mem_valid), 32'h0);
        checkOutput("rst_mem_we", 32'(sbIf.mem_we), 32'h0);
        checkOutput("rst_ld_hazard", 32'(sbIf.ld_hazard), 32'h0);
        @(posedge clk);
        #1;
        rst = 0;
        sbIf.ld_valid = 0;

        // Single aligned-lane store
        applyStimulus(1, 32'h0000_0102, 32'h0000_00AB, 4'b0100, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("single_mem_valid", 32'(sbIf.mem_valid), 32'h1);
        checkOutput("single_mem_addr", 32'(sbIf.mem_addr), 32'h40);
        checkOutput("single_mem_din", sbIf.mem_din, 32'h00AB_0000);
        checkOutput("single_mem_we", 32'(sbIf.mem_we), 32'h4);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("single_empty_after", 32'(sbIf.empty), 32'h1);

        // Fill while memory stalls, then drain in order
        for (int k = 1; k <= 4; k++) applyStimulus(1, 32'(4 * k), 32'h1000 + 32'(k), 4'hF, 0, 0, 0);
        applyStimulus(1, 32'd20, 32'h5555, 4'hF, 0, 0, 0);
        checkOutput("fill_full", 32'(sbIf.full), 32'h1);
        checkOutput("fill_st_ready", 32'(sbIf.st_ready), 32'h0);
        checkOutput("fill_head_addr", 32'(sbIf.mem_addr), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_head_addr", 32'(sbIf.mem_addr), 32'h1);
        drain();

        // Two held entries, simultaneous enqueue and dequeue
        applyStimulus(1, 32'h100, 32'hA0, 4'hF, 0, 0, 0);
        applyStimulus(1, 32'h104, 32'hA1, 4'hF, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(1, 32'h108 + 32'(4 * k), 32'hB0 + 32'(k), 4'hF, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("steady_full", 32'(sbIf.full), 32'h0);
        checkOutput("steady_head_addr", 32'(sbIf.mem_addr), 32'h46);
        drain();

        // Load hazard and zero-mask store
        applyStimulus(1, 32'h40, 32'h1234, 4'hF, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h43);
        checkOutput("hazard_match", 32'(sbIf.ld_hazard), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h44);
        checkOutput("hazard_nomatch", 32'(sbIf.ld_hazard), 32'h0);
        applyStimulus(1, 32'h80, 32'hDEAD, 4'h0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h80);
        checkOutput("zero_mask_hazard", 32'(sbIf.ld_hazard), 32'h0);
        checkOutput("zero_mask_empty", 32'(sbIf.empty), 32'h0);
        drain();

        // Asynchronous reset with three stores held
        for (int k = 0; k < 3; k++) applyStimulus(1, 32'h200 + 32'(4 * k), 32'hC0 + 32'(k), 4'h3, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h200);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        checkOutput("async_empty", 32'(sbIf.empty), 32'h1);
        checkOutput("async_mem_valid", 32'(sbIf.mem_valid), 32'h0);
        checkOutput("async_mem_we", 32'(sbIf.mem_we), 32'h0);
        checkOutput("async_ld_hazard", 32'(sbIf.ld_hazard), 32'h0);
        checkOutput("async_st_ready", 32'(sbIf.st_ready), 32'h1);
        #10;
        @(posedge clk);
        #1;
        rst = 0;
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Random traffic on a small address window so hazards and reuse occur
        for (int k = 0; k < 400; k++) begin
            applyStimulus(logic'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom,
                          4'($urandom_range(0, 15)), logic'($urandom_range(0, 2) != 0),
                          logic'($urandom_range(0, 1)), 32'($urandom_range(0, 31)));
        end
        drain();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
